cache_fill_ctrl: RTL and testbench

//  Miss handler between the split I/D caches and a single shared main memory.

---
 rtl/cache_fill_pkg.sv | 17 +
 rtl/cache_fill_if.sv | 41 ++++
 rtl/cache_fill_ctrl_sat_counter.sv | 19 +
 rtl/cache_fill_ctrl.sv | 130 +++++++++++++
 tb/tb_cache_fill_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/cache_fill_pkg.sv
// cache_fill_pkg: shared constants and state encoding for the cache miss handler.
package cache_fill_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int LINE_W_DEF = 64;
    localparam int CNT_W      = 32;

    // 3-bit state encoding, kept as plain constants so legacy code can compare raw values
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_D_WB   = 3'd1;
    localparam state_t S_D_FILL = 3'd2;
    localparam state_t S_D_WR   = 3'd3;
    localparam state_t S_I_FILL = 3'd4;
    localparam state_t S_I_WR   = 3'd5;

endpackage

// File: rtl/cache_fill_if.sv
// cache_fill_if: cache-side miss/fill signals plus the single shared memory port.
// slave = the fill controller, master = caches + memory (or a testbench).
interface cache_fill_if
    import cache_fill_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
);
    logic              i_miss;
    logic [ADDR_W-1:0] i_addr;
    logic              d_miss;
    logic              d_dirty;
    logic [ADDR_W-1:0] d_addr;
    logic [ADDR_W-1:0] d_victim_addr;
    logic [LINE_W-1:0] d_victim_data;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              i_fill_we;
    logic              d_fill_we;
    logic [LINE_W-1:0] fill_data;
    logic              i_rdy;
    logic              d_rdy;

    modport slave (
        input  i_miss, i_addr, d_miss, d_dirty, d_addr, d_victim_addr, d_victim_data,
        input  mem_rdata, mem_valid,
        output mem_re, mem_we, mem_addr, mem_wdata,
        output i_fill_we, d_fill_we, fill_data, i_rdy, d_rdy
    );

    modport master (
        output i_miss, i_addr, d_miss, d_dirty, d_addr, d_victim_addr, d_victim_data,
        output mem_rdata, mem_valid,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        input  i_fill_we, d_fill_we, fill_data, i_rdy, d_rdy
    );
endinterface

// File: rtl/cache_fill_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // count up on inc, hold once saturated
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: serialises D write-back/refill and I refill over one memory port
// and produces the i_rdy/d_rdy stall signals for the hazard unit.
// Optional: define CACHE_FILL_PERF_CNT_EN to add saturating miss/write-back/stall counters.
module cache_fill_ctrl
    import cache_fill_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    cache_fill_if.slave      bus
`ifdef CACHE_FILL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] i_miss_cnt,
    output logic [CNT_W-1:0] d_miss_cnt,
    output logic [CNT_W-1:0] wb_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    state_t            state, next_state;
    logic [ADDR_W-1:0] i_addr_q, d_addr_q, victim_addr_q;
    logic [LINE_W-1:0] victim_data_q;
    logic [LINE_W-1:0] fill_q;
    logic              leave_idle;
    logic              i_rdy_w, d_rdy_w;

    assign leave_idle = (state == S_IDLE) && (next_state != S_IDLE);

    // next-state: D has priority over I because it belongs to the older instruction
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus.d_miss)
                    next_state = bus.d_dirty ? S_D_WB : S_D_FILL;
                else if (bus.i_miss)
                    next_state = S_I_FILL;
            end
            S_D_WB:   if (bus.mem_valid) next_state = S_D_FILL;
            S_D_FILL: if (bus.mem_valid) next_state = S_D_WR;
            S_I_FILL: if (bus.mem_valid) next_state = S_I_WR;
            S_D_WR:   next_state = S_IDLE;
            S_I_WR:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // state register; reset drops any in-flight request
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // capture request addresses/victim once so the memory request is stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_addr_q      <= '0;
            d_addr_q      <= '0;
            victim_addr_q <= '0;
            victim_data_q <= '0;
        end else if (leave_idle) begin
            i_addr_q      <= bus.i_addr;
            d_addr_q      <= bus.d_addr;
            victim_addr_q <= bus.d_victim_addr;
            victim_data_q <= bus.d_victim_data;
        end
    end

    // register the returned line; it is presented to the cache during *_WR
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fill_q <= '0;
        else if (((state == S_D_FILL) || (state == S_I_FILL)) && bus.mem_valid)
            fill_q <= bus.mem_rdata;
    end

    // Moore decode of the memory port and fill strobes
    always_comb begin
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.i_fill_we = 1'b0;
        bus.d_fill_we = 1'b0;
        case (state)
            S_D_WB: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = victim_addr_q;
                bus.mem_wdata = victim_data_q;
            end
            S_D_FILL: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = d_addr_q;
            end
            S_I_FILL: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = i_addr_q;
            end
            S_D_WR:  bus.d_fill_we = 1'b1;
            S_I_WR:  bus.i_fill_we = 1'b1;
            default: ;
        endcase
    end

    assign i_rdy_w = ~bus.i_miss & (state != S_I_FILL) & (state != S_I_WR);
    assign d_rdy_w = ~bus.d_miss & (state != S_D_WB) & (state != S_D_FILL) & (state != S_D_WR);

    assign bus.i_rdy     = i_rdy_w;
    assign bus.d_rdy     = d_rdy_w;
    assign bus.fill_data = fill_q;

`ifdef CACHE_FILL_PERF_CNT_EN
    logic i_inc, d_inc, wb_inc, stall_inc;

    assign i_inc     = (state == S_IDLE) && (next_state == S_I_FILL);
    assign d_inc     = (state == S_IDLE) && bus.d_miss;
    assign wb_inc    = (state == S_IDLE) && (next_state == S_D_WB);
    assign stall_inc = ~(i_rdy_w & d_rdy_w);

    sat_counter #(.W(CNT_W)) u_i_cnt  (.clk(clk), .rst(rst), .inc(i_inc),     .cnt(i_miss_cnt));
    sat_counter #(.W(CNT_W)) u_d_cnt  (.clk(clk), .rst(rst), .inc(d_inc),     .cnt(d_miss_cnt));
    sat_counter #(.W(CNT_W)) u_wb_cnt (.clk(clk), .rst(rst), .inc(wb_inc),    .cnt(wb_cnt));
    sat_counter #(.W(CNT_W)) u_st_cnt (.clk(clk), .rst(rst), .inc(stall_inc), .cnt(stall_cnt));
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed scenarios for the miss handler. Inputs change and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_cache_fill_ctrl;
    import cache_fill_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    cache_fill_if bus ();

`ifdef CACHE_FILL_PERF_CNT_EN
    logic [CNT_W-1:0] i_miss_cnt, d_miss_cnt, wb_cnt, stall_cnt;
`endif

    cache_fill_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef CACHE_FILL_PERF_CNT_EN
        ,
        .i_miss_cnt (i_miss_cnt),
        .d_miss_cnt (d_miss_cnt),
        .wb_cnt     (wb_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; bus.i_miss = 1'b1; bus.d_miss = 1'b1; bus.d_dirty = 1'b1; bus.mem_valid = 1'b1;
        bus.mem_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk); @(negedge clk);
        checks++; if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL rst_mem_re got=%0h exp=0", bus.mem_re); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%0h exp=0", bus.mem_we); end
        checks++; if ({bus.i_fill_we, bus.d_fill_we} !== 2'b00) begin errors++; $display("FAIL rst_fill_we got=%b exp=00", {bus.i_fill_we, bus.d_fill_we}); end
        checks++; if (bus.fill_data !== 64'h0) begin errors++; $display("FAIL rst_fill_data got=%h exp=0", bus.fill_data); end
        checks++; if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 64'h0) begin errors++; $display("FAIL rst_mem_bus got=%h/%h exp=0/0", bus.mem_addr, bus.mem_wdata); end
        checks++; if ({bus.i_rdy, bus.d_rdy} !== 2'b00) begin errors++; $display("FAIL rst_rdy got=%b exp=00", {bus.i_rdy, bus.d_rdy}); end
        bus.i_miss = 1'b0; bus.d_miss = 1'b0; bus.d_dirty = 1'b0; bus.mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({bus.i_rdy, bus.d_rdy} !== 2'b11) begin errors++; $display("FAIL rst_release_rdy got=%b exp=11", {bus.i_rdy, bus.d_rdy}); end
        checks++; if ({bus.mem_re, bus.mem_we} !== 2'b00) begin errors++; $display("FAIL rst_release_mem got=%b exp=00", {bus.mem_re, bus.mem_we}); end
    endtask

    task automatic test_clean_i_miss();
        bus.i_addr = 16'h0040; bus.i_miss = 1'b1;
        #1;
        checks++; if (bus.i_rdy !== 1'b0) begin errors++; $display("FAIL imiss_rdy_comb got=%0h exp=0", bus.i_rdy); end
        @(negedge clk);
        bus.i_addr = 16'h9999;  // request must stay on the latched address
        #1;
        checks++; if (bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h0040) begin errors++; $display("FAIL imiss_req got=%0h@%h exp=1@0040", bus.mem_re, bus.mem_addr); end
        @(negedge clk); @(negedge clk);
        checks++; if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL imiss_hold got=re%0h we%0h exp=re1 we0", bus.mem_re, bus.mem_we); end
        bus.mem_valid = 1'b1; bus.mem_rdata = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk);
        checks++; if (bus.i_fill_we !== 1'b1 || bus.fill_data !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL imiss_fill got=%0h/%h exp=1/deadbeefcafef00d", bus.i_fill_we, bus.fill_data); end
        checks++; if (bus.mem_re !== 1'b0 || bus.i_rdy !== 1'b0) begin errors++; $display("FAIL imiss_iwr got=re%0h rdy%0h exp=re0 rdy0", bus.mem_re, bus.i_rdy); end
        bus.mem_valid = 1'b0; bus.i_miss = 1'b0; bus.mem_rdata = 64'h0;
        @(negedge clk);
        checks++; if (bus.i_fill_we !== 1'b0 || bus.i_rdy !== 1'b1) begin errors++; $display("FAIL imiss_done got=we%0h rdy%0h exp=we0 rdy1", bus.i_fill_we, bus.i_rdy); end
    endtask

    task automatic test_dirty_d_miss();
        bus.d_miss = 1'b1; bus.d_dirty = 1'b1; bus.d_addr = 16'h0200;
        bus.d_victim_addr = 16'h0100; bus.d_victim_data = 64'hA5A5_0000_FFFF_5A5A;
        @(negedge clk);
        bus.d_victim_data = 64'h0; bus.d_dirty = 1'b0; bus.d_addr = 16'h0777;
        #1;
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_addr !== 16'h0100) begin errors++; $display("FAIL dwb_req got=we%0h re%0h @%h exp=we1 re0 @0100", bus.mem_we, bus.mem_re, bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 64'hA5A5_0000_FFFF_5A5A || bus.d_rdy !== 1'b0) begin errors++; $display("FAIL dwb_data got=%h rdy%0h exp=a5a50000ffff5a5a rdy0", bus.mem_wdata, bus.d_rdy); end
        bus.mem_valid = 1'b1;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        #1;
        checks++; if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0200) begin errors++; $display("FAIL dfill_req got=re%0h we%0h @%h exp=re1 we0 @0200", bus.mem_re, bus.mem_we, bus.mem_addr); end
        @(negedge clk);
        checks++; if (bus.d_rdy !== 1'b0 || bus.d_fill_we !== 1'b0) begin errors++; $display("FAIL dfill_wait got=rdy%0h we%0h exp=rdy0 we0", bus.d_rdy, bus.d_fill_we); end
        bus.mem_valid = 1'b1; bus.mem_rdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        checks++; if (bus.d_fill_we !== 1'b1 || bus.fill_data !== 64'h0123_4567_89AB_CDEF || bus.d_rdy !== 1'b0) begin errors++; $display("FAIL dwr got=we%0h %h rdy%0h exp=we1 0123456789abcdef rdy0", bus.d_fill_we, bus.fill_data, bus.d_rdy); end
        bus.mem_valid = 1'b0; bus.d_miss = 1'b0;
        @(negedge clk);
        checks++; if (bus.d_fill_we !== 1'b0 || bus.d_rdy !== 1'b1) begin errors++; $display("FAIL ddone got=we%0h rdy%0h exp=we0 rdy1", bus.d_fill_we, bus.d_rdy); end
    endtask

    task automatic test_back_to_back();
        bus.i_miss = 1'b1; bus.i_addr = 16'h0033;
        bus.d_miss = 1'b1; bus.d_dirty = 1'b0; bus.d_addr = 16'h0044;
        @(negedge clk);
        checks++; if (bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h0044 || bus.i_rdy !== 1'b0) begin errors++; $display("FAIL b2b_d_first got=re%0h @%h irdy%0h exp=re1 @0044 irdy0", bus.mem_re, bus.mem_addr, bus.i_rdy); end
        bus.mem_valid = 1'b1; bus.mem_rdata = 64'hD0D0_D0D0_D0D0_D0D0;
        @(negedge clk);
        checks++; if (bus.d_fill_we !== 1'b1 || bus.i_rdy !== 1'b0) begin errors++; $display("FAIL b2b_dwr got=we%0h irdy%0h exp=we1 irdy0", bus.d_fill_we, bus.i_rdy); end
        bus.mem_valid = 1'b0; bus.d_miss = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_re !== 1'b0 || bus.i_rdy !== 1'b0 || bus.d_rdy !== 1'b1) begin errors++; $display("FAIL b2b_bubble got=re%0h irdy%0h drdy%0h exp=re0 irdy0 drdy1", bus.mem_re, bus.i_rdy, bus.d_rdy); end
        @(negedge clk);
        checks++; if (bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h0033) begin errors++; $display("FAIL b2b_i_req got=re%0h @%h exp=re1 @0033", bus.mem_re, bus.mem_addr); end
        bus.mem_valid = 1'b1; bus.mem_rdata = 64'h1E1E_1E1E_1E1E_1E1E;
        @(negedge clk);
        checks++; if (bus.i_fill_we !== 1'b1 || bus.i_rdy !== 1'b0 || bus.fill_data !== 64'h1E1E_1E1E_1E1E_1E1E) begin errors++; $display("FAIL b2b_iwr got=we%0h irdy%0h %h exp=we1 irdy0 1e1e1e1e1e1e1e1e", bus.i_fill_we, bus.i_rdy, bus.fill_data); end
        bus.mem_valid = 1'b0; bus.i_miss = 1'b0;
        @(negedge clk);
        checks++; if (bus.i_rdy !== 1'b1 || bus.i_fill_we !== 1'b0) begin errors++; $display("FAIL b2b_done got=irdy%0h we%0h exp=irdy1 we0", bus.i_rdy, bus.i_fill_we); end
    endtask

    task automatic test_reset_mid_fill();
        bus.d_miss = 1'b1; bus.d_dirty = 1'b0; bus.d_addr = 16'h0055;
        @(negedge clk);
        checks++; if (bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h0055) begin errors++; $display("FAIL rmid_req got=re%0h @%h exp=re1 @0055", bus.mem_re, bus.mem_addr); end
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_re !== 1'b0 || bus.mem_addr !== 16'h0) begin errors++; $display("FAIL rmid_abort got=re%0h @%h exp=re0 @0000", bus.mem_re, bus.mem_addr); end
        bus.d_miss = 1'b0;
        @(negedge clk);
        rst = 1'b0; bus.mem_valid = 1'b1; bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        checks++; if ({bus.i_fill_we, bus.d_fill_we} !== 2'b00 || bus.fill_data !== 64'h0) begin errors++; $display("FAIL rmid_stray got=%b %h exp=00 0", {bus.i_fill_we, bus.d_fill_we}, bus.fill_data); end
        bus.mem_valid = 1'b0;
        @(negedge clk);
        checks++; if ({bus.i_fill_we, bus.d_fill_we, bus.mem_re, bus.mem_we} !== 4'b0000 || bus.d_rdy !== 1'b1) begin errors++; $display("FAIL rmid_idle got=%b rdy%0h exp=0000 rdy1", {bus.i_fill_we, bus.d_fill_we, bus.mem_re, bus.mem_we}, bus.d_rdy); end
    endtask

`ifdef CACHE_FILL_PERF_CNT_EN
    // each I miss with an immediate response stalls 3 cycles (IDLE, I_FILL, I_WR);
    // the dirty D miss stalls 4 (IDLE, D_WB, D_FILL, D_WR) -> 10 total
    task automatic do_i_miss(input logic [15:0] a);
        bus.i_miss = 1'b1; bus.i_addr = a;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        @(negedge clk);
        bus.mem_valid = 1'b0; bus.i_miss = 1'b0;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_perf_cnt();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (stall_cnt !== 32'd0 || i_miss_cnt !== 32'd0) begin errors++; $display("FAIL perf_clear got=%0d/%0d exp=0/0", stall_cnt, i_miss_cnt); end
        do_i_miss(16'h0010);
        do_i_miss(16'h0020);
        bus.d_miss = 1'b1; bus.d_dirty = 1'b1; bus.d_addr = 16'h0030; bus.d_victim_addr = 16'h0031;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        bus.mem_valid = 1'b0; bus.d_miss = 1'b0; bus.d_dirty = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (i_miss_cnt !== 32'd2) begin errors++; $display("FAIL perf_i_miss got=%0d exp=2", i_miss_cnt); end
        checks++; if (d_miss_cnt !== 32'd1) begin errors++; $display("FAIL perf_d_miss got=%0d exp=1", d_miss_cnt); end
        checks++; if (wb_cnt !== 32'd1) begin errors++; $display("FAIL perf_wb got=%0d exp=1", wb_cnt); end
        checks++; if (stall_cnt !== 32'd10) begin errors++; $display("FAIL perf_stall got=%0d exp=10", stall_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b0;
        bus.i_miss = 1'b0; bus.i_addr = '0; bus.d_miss = 1'b0; bus.d_dirty = 1'b0;
        bus.d_addr = '0; bus.d_victim_addr = '0; bus.d_victim_data = '0;
        bus.mem_rdata = '0; bus.mem_valid = 1'b0;
        test_reset();
        test_clean_i_miss();
        test_dirty_d_miss();
        test_back_to_back();
        test_reset_mid_fill();
`ifdef CACHE_FILL_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
